// File: rtl/chn_in_pkt_buffer.sv
// chn_in_pkt_buffer: speculative packet writer into a show-ahead FIFO; only complete, valid packets become visible.
// Define CHN_IN_PARITY_EN to require a trailing XOR parity beat per packet.
module chn_in_pkt_buffer #(
  parameter int DATA_SIZE       = 8,
  parameter int PKT_LENGTH_BITS = 5,
  parameter int PKT_ADDR_BITS   = DATA_SIZE - PKT_LENGTH_BITS,
  parameter int NUM_CHN         = 4,
  parameter int FIFO_DEPTH      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chn_en,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 clr_errors,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_rdy,
  output logic                 busy,
  output logic                 pkt_to_fifo_en,
  output logic                 error,
  output logic [3:0]           err_status
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY, DROP} state_t;
  state_t state, state_n;
  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, sp_ptr, rd_ptr, sp_nxt, used;
  logic [PKT_LENGTH_BITS-1:0] rem, hdr_len;
  logic [PKT_ADDR_BITS-1:0] hdr_addr;
  logic [3:0] err, err_set;
  logic prev_en, wr_en, commit, rollback, pop, bad_hdr, no_room;
`ifdef CHN_IN_PARITY_EN
  logic [DATA_SIZE-1:0] par;
`endif
  assign hdr_len = data_in[PKT_LENGTH_BITS-1:0];
  assign hdr_addr = data_in[DATA_SIZE-1:PKT_LENGTH_BITS];
  assign used = sp_ptr - rd_ptr;
  assign bad_hdr = hdr_len == '0 || {1'b0, hdr_addr} >= (PKT_ADDR_BITS+1)'(NUM_CHN);
  assign no_room = ({1'b0, used} + (AW+2)'(hdr_len) + (AW+2)'(1)) > (AW+2)'(FIFO_DEPTH);
  assign data_out_valid = wr_ptr != rd_ptr;
  assign data_out = data_out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign pop = data_out_valid && data_out_rdy;
  assign sp_nxt = rollback ? wr_ptr : sp_ptr + {{AW{1'b0}}, wr_en};
  assign busy = state != IDLE;
  assign err_status = err;
  assign error = |err;
  assign pkt_to_fifo_en = commit;
  always_comb begin
    state_n = state;
    wr_en = 1'b0;
    commit = 1'b0;
    rollback = 1'b0;
    err_set = 4'b0;
    case (state)
      IDLE:
        if (chn_en && !prev_en) begin
          err_set[1] = bad_hdr;
          err_set[2] = !bad_hdr && no_room;
          wr_en = !bad_hdr && !no_room;
          state_n = wr_en ? PAYLOAD : DROP;
        end
      PAYLOAD:
        if (!chn_en) begin
          rollback = 1'b1;
          err_set[3] = 1'b1;
          state_n = IDLE;
        end else begin
          wr_en = 1'b1;
          if (rem == PKT_LENGTH_BITS'(1)) begin
`ifdef CHN_IN_PARITY_EN
            state_n = PARITY;
`else
            commit = 1'b1;
            state_n = IDLE;
`endif
          end
        end
`ifdef CHN_IN_PARITY_EN
      PARITY: begin
        commit = chn_en && data_in == par;
        rollback = !commit;
        err_set[3] = !chn_en;
        err_set[0] = chn_en && data_in != par;
        state_n = IDLE;
      end
`endif
      DROP: state_n = chn_en ? DROP : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      sp_ptr <= '0;
      rd_ptr <= '0;
      rem <= '0;
      prev_en <= 1'b0;
      err <= '0;
`ifdef CHN_IN_PARITY_EN
      par <= '0;
`endif
    end else begin
      state <= state_n;
      prev_en <= chn_en;
      sp_ptr <= sp_nxt;
      wr_ptr <= commit ? sp_nxt : wr_ptr;
      rd_ptr <= rd_ptr + {{AW{1'b0}}, pop};
      err <= (clr_errors ? 4'b0 : err) | err_set;
      if (wr_en) rem <= state == IDLE ? hdr_len : rem - 1'b1;
`ifdef CHN_IN_PARITY_EN
      if (wr_en) par <= state == IDLE ? data_in : par ^ data_in;
`endif
    end
  always_ff @(posedge clk)
    if (wr_en) mem[sp_ptr[AW-1:0]] <= data_in;
endmodule

// File: tb/tb_chn_in_pkt_buffer.sv
// tb_chn_in_pkt_buffer: scoreboard bench for chn_in_pkt_buffer (default parameters).
module tb_chn_in_pkt_buffer;
  logic clk = 1'b0, rst = 1'b1, chn_en = 1'b0, clr_errors = 1'b0, data_out_rdy = 1'b1;
  logic [7:0] data_in = 8'h0;
  logic [7:0] data_out;
  logic data_out_valid, busy, pkt_to_fifo_en, error;
  logic [3:0] err_status;
  int n_chk = 0, n_pass = 0, pulses = 0;
  logic [7:0] sb [$];

  chn_in_pkt_buffer dut (
    .clk(clk), .rst(rst), .chn_en(chn_en), .data_in(data_in), .clr_errors(clr_errors),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_rdy(data_out_rdy),
    .busy(busy), .pkt_to_fifo_en(pkt_to_fifo_en), .error(error), .err_status(err_status)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (pkt_to_fifo_en) pulses++;
      if (data_out_valid && data_out_rdy) begin
        if (sb.size() == 0) check("spurious_pop", 32'(data_out_valid), 32'h0);
        else check("data", 32'(data_out), 32'(sb.pop_front()));
      end
    end

  task automatic drive(logic en, logic [7:0] d);
    chn_en = en;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(logic [7:0] hdr, logic [7:0] base, logic [7:0] step, bit good);
    logic [7:0] p = hdr;
    logic [7:0] b;
    if (good) sb.push_back(hdr);
    drive(1'b1, hdr);
    for (int i = 0; i < int'(hdr[4:0]); i++) begin
      b = base + 8'(i) * step;
      p ^= b;
      if (good) sb.push_back(b);
      drive(1'b1, b);
    end
`ifdef CHN_IN_PARITY_EN
    drive(1'b1, good ? p : ~p);
`endif
    drive(1'b0, 8'h0);
  endtask

  task automatic wait_drain(string tag);
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, 32'(sb.size()), 32'h0);
  endtask

  task automatic clear_errs();
    clr_errors = 1'b1;
    @(posedge clk);
    #1;
    clr_errors = 1'b0;
    check("clr", 32'(err_status), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(data_out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err_status), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_dout", 32'(data_out), 32'h0);
    check("rst_pulse", 32'(pkt_to_fifo_en), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // good packet
    send_pkt(8'h23, 8'h11, 8'h11, 1'b1);
    wait_drain("drain_good");
    check("pulses_good", 32'(pulses), 32'h1);
    check("error_good", 32'(error), 32'h0);
`ifdef CHN_IN_PARITY_EN
    send_pkt(8'h23, 8'h11, 8'h11, 1'b0);
    repeat (3) drive(1'b0, 8'h0);
    check("par_valid", 32'(data_out_valid), 32'h0);
    check("par_err", 32'(err_status), 32'h1);
    clear_errs();
`endif
    // bad address
    drive(1'b1, 8'hA2);
    check("badhdr_err", 32'(err_status), 32'h2);
    check("badhdr_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h31 + i));
    check("drop_busy", 32'(busy), 32'h1);
    drive(1'b0, 8'h0);
    check("drop_idle", 32'(busy), 32'h0);
    check("drop_valid", 32'(data_out_valid), 32'h0);
    clear_errs();
    // zero length
    drive(1'b1, 8'h20);
    drive(1'b0, 8'h0);
    check("len0_err", 32'(err_status), 32'h2);
    clear_errs();
    // truncation
    drive(1'b1, 8'h04);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    drive(1'b0, 8'h0);
    check("trunc_err", 32'(err_status), 32'h8);
    check("trunc_busy", 32'(busy), 32'h0);
    drive(1'b0, 8'h0);
    check("trunc_valid", 32'(data_out_valid), 32'h0);
    clear_errs();
    send_pkt(8'h24, 8'h70, 8'h03, 1'b1);
    wait_drain("drain_after_trunc");
    check("err_after_trunc", 32'(err_status), 32'h0);
    // chn_en held high past packet end is not a new header
    sb.push_back(8'h01);
    sb.push_back(8'h5A);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h5A);
`ifdef CHN_IN_PARITY_EN
    drive(1'b1, 8'h5B);
`endif
    drive(1'b1, 8'h21);
    check("held_en_busy", 32'(busy), 32'h0);
    drive(1'b0, 8'h0);
    wait_drain("drain_held");
    check("held_err", 32'(err_status), 32'h0);
    // overflow with a full FIFO, then drain across the pointer wrap
    data_out_rdy = 1'b0;
    pulses = 0;
    send_pkt(8'h1F, 8'h40, 8'h01, 1'b1);
    send_pkt(8'h1F, 8'h80, 8'h01, 1'b1);
    check("ovf_pulses", 32'(pulses), 32'h2);
    check("stall_head", 32'(data_out), 32'h1F);
    drive(1'b1, 8'h1F);
    check("ovf_err", 32'(err_status), 32'h4);
    check("ovf_busy", 32'(busy), 32'h1);
    drive(1'b1, 8'h55);
    drive(1'b0, 8'h0);
    data_out_rdy = 1'b1;
    wait_drain("drain_ovf");
    check("ovf_sticky", 32'(err_status), 32'h4);
    clear_errs();
    // reset in PAYLOAD with committed data present
    data_out_rdy = 1'b0;
    send_pkt(8'h02, 8'hAA, 8'h11, 1'b1);
    drive(1'b1, 8'h03);
    drive(1'b1, 8'h44);
    check("pre_rst_busy", 32'(busy), 32'h1);
    check("pre_rst_valid", 32'(data_out_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_valid", 32'(data_out_valid), 32'h0);
    check("arst_dout", 32'(data_out), 32'h0);
    check("arst_error", 32'(error), 32'h0);
    check("arst_pulse", 32'(pkt_to_fifo_en), 32'h0);
    sb.delete();
    chn_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_out_rdy = 1'b1;
    drive(1'b0, 8'h0);
    send_pkt(8'h43, 8'h05, 8'h07, 1'b1);
    wait_drain("drain_after_rst");
    check("err_after_rst", 32'(err_status), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/chn_in_pkt_buffer.md
CHN_IN_PKT_BUFFER -- requirements
Module: chn_in_pkt_buffer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, beat width in bits.
REQ-002 SHALL have parameter PKT_LENGTH_BITS, default 5, width of the header length field at bits [PKT_LENGTH_BITS-1:0].
REQ-003 SHALL have parameter PKT_ADDR_BITS, default DATA_SIZE-PKT_LENGTH_BITS, width of the header address field at bits [DATA_SIZE-1:PKT_LENGTH_BITS].
REQ-004 SHALL have parameter NUM_CHN, default 4, number of valid destinations; it must be at most 2**PKT_ADDR_BITS.
REQ-005 SHALL have parameter FIFO_DEPTH, default 64, a power of two of at least 2**PKT_LENGTH_BITS+1.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port chn_en, input, 1 bit: packet framing, held high for every beat of a packet.
REQ-009 SHALL have port data_in, input, DATA_SIZE bits: the packet beat.
REQ-010 SHALL have port clr_errors, input, 1 bit: synchronous clear of the error status.
REQ-011 SHALL have port data_out, output, DATA_SIZE bits: the FIFO head beat.
REQ-012 SHALL have port data_out_valid, output, 1 bit: a committed beat is available.
REQ-013 SHALL have port data_out_rdy, input, 1 bit: the consumer accepts data_out.
REQ-014 SHALL have port busy, output, 1 bit: a packet is in progress.
REQ-015 SHALL have port pkt_to_fifo_en, output, 1 bit: one-cycle pulse when a packet is committed.
REQ-016 SHALL have port error, output, 1 bit: OR of err_status.
REQ-017 SHALL have port err_status, output, 4 bits: sticky flags {trunc, overflow, bad_hdr, parity} from bit 3 down to bit 0.

Function
REQ-018 SHALL implement FSM states IDLE, PAYLOAD, PARITY and DROP.
REQ-019 In IDLE, a cycle with chn_en=1 SHALL capture data_in as the header.
  - If length==0 or addr>=NUM_CHN: set bad_hdr and go to DROP.
  - Else if free space < length+1: set overflow and go to DROP.
  - Otherwise: write the header speculatively and go to PAYLOAD.
REQ-020 In PAYLOAD, each chn_en=1 cycle SHALL write data_in speculatively and decrement the remaining count; after the last payload beat the FSM SHALL go to PARITY.
REQ-021 In PARITY, with chn_en=1, the block SHALL compare data_in against the XOR of the header and all payload beats.
  - On a match: commit (write pointer := speculative pointer) and pulse pkt_to_fifo_en.
  - On a mismatch: roll back (speculative pointer := write pointer) and set parity.
  - In both cases the FSM SHALL return to IDLE.
REQ-022 chn_en=0 in PAYLOAD or PARITY SHALL roll back, set trunc and return to IDLE in the same cycle.
REQ-023 DROP SHALL discard beats while chn_en=1 and return to IDLE on the first chn_en=0 cycle.
REQ-024 busy SHALL equal (state!=IDLE).
REQ-025 After IDLE, chn_en SHALL be sampled as a new header only after at least one chn_en=0 cycle.
REQ-026 Only committed beats SHALL be visible: data_out_valid rises the cycle after the pkt_to_fifo_en pulse, never for speculative beats.
REQ-027 data_out SHALL be show-ahead (equal to the head beat whenever data_out_valid=1); a beat pops on data_out_valid&&data_out_rdy.
REQ-028 Free space SHALL be FIFO_DEPTH-(speculative pointer-read pointer); pointers SHALL be $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
REQ-029 A pop and a commit in the same cycle SHALL both take effect.
REQ-030 Pops SHALL continue during any write state, DROP or rollback.
REQ-031 clr_errors SHALL zero err_status next cycle; a new error in the same cycle SHALL win, leaving that bit set.
REQ-032 The header SHALL be stored in the FIFO ahead of the payload; the parity beat SHALL not be stored.

Reset
REQ-033 rst=1 SHALL immediately force:
  - state=IDLE;
  - all pointers=0;
  - data_out_valid=0, busy=0, pkt_to_fifo_en=0, error=0, err_status=0;
  - data_out=0.
REQ-034 Reset mid-packet SHALL discard all speculative and committed contents.

Configuration
REQ-035 With CHN_IN_PARITY_EN defined, the PARITY state and parity check SHALL exist as in REQ-021.
REQ-036 Without CHN_IN_PARITY_EN, the block SHALL commit on the last payload beat, PAYLOAD SHALL go directly to IDLE, and err_status[0] SHALL be tied to 0.

Verification
REQ-037 Header 8'h23 (addr 1, len 3), payload 8'h11, 8'h22, 8'h33, parity 8'h23, data_out_rdy=1 -> one pkt_to_fifo_en pulse, then data_out 23, 11, 22, 33, error=0.
REQ-038 The same packet with parity 8'h00 -> no data_out_valid, err_status=4'b0001, and clr_errors restores 0.
REQ-039 Header 8'hA2 (addr 5, NUM_CHN=4) -> bad_hdr set, all 3 following beats dropped, and busy falls after chn_en=0.
REQ-040 chn_en dropped after the 2nd payload beat of a len-4 packet -> trunc set, FIFO count unchanged, and the next packet commits normally.
REQ-041 data_out_rdy=0 with two len-31 packets committed (FIFO_DEPTH=64), then a third header -> overflow set; then 64 pops with rdy=1 -> pointers wrap and data stays correct.
REQ-042 rst asserted in the PAYLOAD state -> all outputs 0 at once, and a packet sent after release is received intact.
